// File: rtl/register_file_32x_pkg.sv
// Shared constants for the 32-entry register file and its write decoder.
// Optional build macro used by the top: REGFILE_ZERO_REG_EN (register 0 reads as zero).
package register_file_32x_pkg;

    localparam int REG_ADDR_W     = 5;
    localparam int NUM_REGS       = 32;
    localparam int DATA_W_DEFAULT = 32;
    localparam int ZERO_REG_IDX   = 0;

endpackage

// File: rtl/register_file_32x_decoder_5to32.sv
// 5-to-32 one-hot write-strobe decoder, gated by the write enable.
module decoder_5to32
    import register_file_32x_pkg::*;
(
    input  logic                  ena_i,
    input  logic [REG_ADDR_W-1:0] addr_i,
    output logic [NUM_REGS-1:0]   strb_o
);

    // The address is only looked at when enabled, so X on addr_i is harmless while idle.
    always_comb begin
        strb_o = '0;
        if (ena_i) begin
            strb_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/register_file_32x_mux32.sv
// 32-to-1 read-select mux; one instance per read port.
module mux32
    import register_file_32x_pkg::*;
#(
    parameter int W = DATA_W_DEFAULT
) (
    input  logic [NUM_REGS-1:0][W-1:0] data_i,
    input  logic [REG_ADDR_W-1:0]      sel_i,
    output logic [W-1:0]               data_o
);

    assign data_o = data_i[sel_i];

endmodule

// File: rtl/register_file_32x.sv
// 32 x N register file: one synchronous write port, two combinational read ports, no bypass.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero (no flop, writes ignored).
module register_file_32x
    import register_file_32x_pkg::*;
#(
    parameter int N = DATA_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_ena,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [N-1:0]          wr_data,
    input  logic [REG_ADDR_W-1:0] rd_addr0,
    input  logic [REG_ADDR_W-1:0] rd_addr1,
    output logic [N-1:0]          rd_data0,
    output logic [N-1:0]          rd_data1
);

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG_EN = 1'b1;
`else
    localparam bit ZERO_REG_EN = 1'b0;
`endif

    logic [NUM_REGS-1:0]        wr_strb;
    logic [NUM_REGS-1:0][N-1:0] reg_bus;

    decoder_5to32 u_wr_dec (
        .ena_i  (wr_ena),
        .addr_i (wr_addr),
        .strb_o (wr_strb)
    );

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        if (ZERO_REG_EN && (gi == ZERO_REG_IDX)) begin : g_zero
            assign reg_bus[gi] = '0;
        end else begin : g_flop
            logic [N-1:0] data_q;
            logic [N-1:0] data_d;

            // Reset wins over a same-cycle write.
            always_comb begin
                data_d = data_q;
                if (wr_strb[gi]) begin
                    data_d = wr_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q <= '0;
                end else begin
                    data_q <= data_d;
                end
            end

            assign reg_bus[gi] = data_q;
        end
    end

    mux32 #(.W(N)) u_rd_mux0 (
        .data_i (reg_bus),
        .sel_i  (rd_addr0),
        .data_o (rd_data0)
    );

    mux32 #(.W(N)) u_rd_mux1 (
        .data_i (reg_bus),
        .sel_i  (rd_addr1),
        .data_o (rd_data1)
    );

endmodule

// File: tb/tb_register_file_32x.sv
// Directed plus randomized self-checking bench for register_file_32x against an array model.
`timescale 1ns/1ps
module tb_register_file_32x;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_ena = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [4:0]  rd_addr0 = '0;
    logic [4:0]  rd_addr1 = '0;
    logic [31:0] rd_data0;
    logic [31:0] rd_data1;

    int checks = 0;
    int failures = 0;

    logic [31:0] model [32];

    register_file_32x #(.N(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_ena   (wr_ena),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] expect_rd(input logic [4:0] a);
        if (ZERO_EN && a == 5'd0) return 32'h0;
        return model[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge with the given write-side inputs; the model follows the spec rules.
    task automatic step(input logic r, input logic e, input logic [4:0] a, input logic [31:0] d);
        rst = r; wr_ena = e; wr_addr = a; wr_data = d;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (e && !(ZERO_EN && a == 5'd0)) begin
            model[a] = d;
        end
        #1;
        rst = 1'b0; wr_ena = 1'b0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_addr0 = 5'(i);
            rd_addr1 = 5'(31 - i);
            #1;
            check({tag, "_p0"}, rd_data0, expect_rd(5'(i)));
            check({tag, "_p1"}, rd_data1, expect_rd(5'(31 - i)));
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        step(1'b1, 1'b0, 5'd0, 32'h0);
        check_all("reset_init");

        // Preload random contents, then reset while a write is pending.
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 5'($urandom_range(31)), $urandom);
        check_all("preload");
        step(1'b1, 1'b1, 5'd12, 32'h1);
        check_all("reset_after_preload");

        // Basic write/read.
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
        step(1'b0, 1'b1, 5'd31, 32'h12345678);
        rd_addr0 = 5'd5; rd_addr1 = 5'd31; #1;
        check("basic_r5", rd_data0, 32'hDEADBEEF);
        check("basic_r31", rd_data1, 32'h12345678);
        check_all("basic_all");

        // Write disabled with live address/data.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd7, 32'hFFFFFFFF);
        rd_addr0 = 5'd7; #1;
        check("wr_disabled_r7", rd_data0, 32'h0);

        // Read during write: old value before the edge, new after.
        step(1'b0, 1'b1, 5'd9, 32'hA5A5A5A5);
        rd_addr0 = 5'd9; rd_addr1 = 5'd9;
        wr_ena = 1'b1; wr_addr = 5'd9; wr_data = 32'h5A5A5A5A; #1;
        check("rdw_before_p0", rd_data0, 32'hA5A5A5A5);
        check("rdw_before_p1", rd_data1, 32'hA5A5A5A5);
        step(1'b0, 1'b1, 5'd9, 32'h5A5A5A5A);
        check("rdw_after_p0", rd_data0, 32'h5A5A5A5A);
        check("rdw_after_p1", rd_data1, 32'h5A5A5A5A);

        // Reset/write collision: pre-reset contents visible until the edge.
        step(1'b0, 1'b1, 5'd3, 32'h77770003);
        rd_addr0 = 5'd3; rd_addr1 = 5'd5;
        rst = 1'b1; wr_ena = 1'b1; wr_addr = 5'd3; wr_data = 32'h1; #1;
        check("rst_cycle_pre_r3", rd_data0, 32'h77770003);
        check("rst_cycle_pre_r5", rd_data1, 32'hDEADBEEF);
        step(1'b1, 1'b1, 5'd3, 32'h1);
        check("rst_collision_r3", rd_data0, 32'h0);
        check("rst_collision_r5", rd_data1, 32'h0);

        // Zero register behaviour depends on the build option.
        step(1'b0, 1'b1, 5'd0, 32'hCAFEF00D);
        rd_addr0 = 5'd0; rd_addr1 = 5'd0; #1;
        check("zero_reg_p0", rd_data0, ZERO_EN ? 32'h0 : 32'hCAFEF00D);
        check("zero_reg_p1", rd_data1, ZERO_EN ? 32'h0 : 32'hCAFEF00D);

        // Randomized traffic with occasional resets, checked before and after each edge.
        for (int n = 0; n < 400; n++) begin
            logic        r, e;
            logic [4:0]  a;
            logic [31:0] d;
            r = ($urandom_range(49) == 0);
            e = ($urandom_range(3) != 0);
            a = 5'($urandom_range(31));
            d = $urandom;
            rd_addr0 = ($urandom_range(2) == 0) ? a : 5'($urandom_range(31));
            rd_addr1 = ($urandom_range(3) == 0) ? rd_addr0 : 5'($urandom_range(31));
            rst = r; wr_ena = e; wr_addr = a; wr_data = d; #1;
            check("rand_pre_p0", rd_data0, expect_rd(rd_addr0));
            check("rand_pre_p1", rd_data1, expect_rd(rd_addr1));
            step(r, e, a, d);
            check("rand_post_p0", rd_data0, expect_rd(rd_addr0));
            check("rand_post_p1", rd_data1, expect_rd(rd_addr1));
        end
        check_all("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
